stdp_lif_array: RTL and testbench

// - N_IN-input leaky integrate-and-fire neuron with on-chip pair-based STDP learning.
// - Parametrised successor to the single-current LIF neuron:
//   - per-channel spike inputs with programmable synaptic weights;
//   - refractory period;
//   - trace-windowed LTP/LTD weight updates.
// - Sits between the tile's input pins (spike vector) and its output pins (spike + membrane state).

---
 rtl/stdp_pkg.sv | 30 +++
 rtl/stdp_synapse.sv | 59 +++++
 rtl/stdp_lif_array.sv | 116 +++++++++++
 tb/tb_stdp_lif_array.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared constants and saturating arithmetic helpers for the STDP LIF neuron array.
package stdp_pkg;

    localparam int N_IN_DEF        = 8;
    localparam int V_WIDTH_DEF     = 8;
    localparam int TRACE_WIDTH_DEF = 3;
    localparam int TMAX            = (1 << TRACE_WIDTH_DEF) - 1;
    localparam int SUM_WIDTH_DEF   = V_WIDTH_DEF + $clog2(N_IN_DEF) + 1;

    function automatic int trace_max(input int trace_width);
        return (1 << trace_width) - 1;
    endfunction

    function automatic int sat_add(input int a, input int b, input int max_val);
        int s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? (a - b) : 0;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One synapse: weight register, presynaptic trace and its pair-based STDP update.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int W_WIDTH     = 8,
    parameter int TRACE_WIDTH = 3,
    parameter int W_INIT      = 16,
    parameter int A_PLUS      = 8,
    parameter int A_MINUS     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               learn_en,
    input  logic               in_spike,
    input  logic               fire,
    input  logic               post_nz,
    input  logic               wr,
    input  logic [W_WIDTH-1:0] wdata,
    output logic [W_WIDTH-1:0] w,
    output logic               pre_nz
);

    localparam int WX = W_WIDTH + 2;
    localparam logic [TRACE_WIDTH-1:0] TMAX_T = TRACE_WIDTH'(trace_max(TRACE_WIDTH));

    logic [TRACE_WIDTH-1:0] pre;
    logic                   ltp;
    logic                   ltd;
    logic signed [WX-1:0]   w_calc;
    logic [W_WIDTH-1:0]     w_next;

    assign pre_nz = (pre != '0);
    assign ltp    = fire & (pre_nz | in_spike);
    assign ltd    = in_spike & post_nz & ~fire;

    // Two spare bits let the sum dip below zero or pass the top before clamping.
    always_comb begin
        w_calc = signed'({2'b00, w});
        if (ltp) w_calc = w_calc + WX'(A_PLUS);
        if (ltd) w_calc = w_calc - WX'(A_MINUS);
        w_next = W_WIDTH'(clamp(int'(w_calc), 0, (1 << W_WIDTH) - 1));
    end

    // Host write sits last so it wins over a learning update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            w   <= W_WIDTH'(W_INIT);
            pre <= '0;
        end else begin
            if (en) begin
                pre <= in_spike ? TMAX_T : TRACE_WIDTH'(sat_sub(int'(pre), 1));
                if (learn_en) w <= w_next;
            end
            if (wr) w <= wdata;
        end
    end

endmodule

// File: rtl/stdp_lif_array.sv
// Multi-input leaky integrate-and-fire neuron with refractory period and on-chip STDP.
module stdp_lif_array
    import stdp_pkg::*;
#(
    parameter int N_IN        = 8,
    parameter int W_WIDTH     = 8,
    parameter int V_WIDTH     = 8,
    parameter int TRACE_WIDTH = 3,
    parameter int LEAK_SHIFT  = 3,
    parameter int THRESHOLD   = 128,
    parameter int REFRACT     = 3,
    parameter int W_INIT      = 16,
    parameter int A_PLUS      = 8,
    parameter int A_MINUS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    learn_en,
    input  logic [N_IN-1:0]         in_spike,
    input  logic [$clog2(N_IN)-1:0] w_sel,
    input  logic                    w_wr,
    input  logic [W_WIDTH-1:0]      w_wdata,
    output logic [W_WIDTH-1:0]      w_rdata,
    output logic                    spike,
    output logic [V_WIDTH-1:0]      state
);

    localparam int SUM_W = V_WIDTH + $clog2(N_IN) + 1;
    localparam int RW    = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int VMAX  = (1 << V_WIDTH) - 1;
    localparam logic [TRACE_WIDTH-1:0] TMAX_T = TRACE_WIDTH'(trace_max(TRACE_WIDTH));

    logic [W_WIDTH-1:0]     w_arr [N_IN];
    logic [N_IN-1:0]        wr_hit;
    logic [SUM_W-1:0]       sum;
    logic [V_WIDTH-1:0]     v;
    logic [V_WIDTH-1:0]     v_leak;
    logic [V_WIDTH-1:0]     vi;
    logic [RW-1:0]          refr_cnt;
    logic [TRACE_WIDTH-1:0] post;
    logic                   post_nz;
    logic                   fire;

    assign post_nz = (post != '0);
    assign state   = v;

    for (genvar i = 0; i < N_IN; i++) begin : g_syn
        assign wr_hit[i] = w_wr && (int'(w_sel) == i);

        stdp_synapse #(
            .W_WIDTH    (W_WIDTH),
            .TRACE_WIDTH(TRACE_WIDTH),
            .W_INIT     (W_INIT),
            .A_PLUS     (A_PLUS),
            .A_MINUS    (A_MINUS)
        ) u_syn (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .learn_en(learn_en),
            .in_spike(in_spike[i]),
            .fire    (fire),
            .post_nz (post_nz),
            .wr      (wr_hit[i]),
            .wdata   (w_wdata),
            .w       (w_arr[i]),
            .pre_nz  ()
        );
    end

    // Sum is wide enough for every channel at full weight, so it never wraps.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_spike[i]) sum = sum + SUM_W'(w_arr[i]);
        end
    end

    always_comb begin
        v_leak = v - (v >> LEAK_SHIFT);
        vi     = V_WIDTH'(sat_add(int'(v_leak), int'(sum), VMAX));
        fire   = (refr_cnt == '0) && (int'(vi) >= THRESHOLD);
    end

    always_comb begin
        w_rdata = '0;
        if (int'(w_sel) < N_IN) w_rdata = w_arr[w_sel];
    end

    // spike defaults low every edge so a pulse lasts exactly one cycle, even with en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            v        <= '0;
            spike    <= 1'b0;
            refr_cnt <= '0;
            post     <= '0;
        end else begin
            spike <= 1'b0;
            if (en) begin
                post <= fire ? TMAX_T : TRACE_WIDTH'(sat_sub(int'(post), 1));
                if (refr_cnt != '0) begin
                    v        <= '0;
                    refr_cnt <= refr_cnt - RW'(1);
                end else if (fire) begin
                    spike    <= 1'b1;
                    v        <= '0;
                    refr_cnt <= RW'(REFRACT);
                end else begin
                    v <= vi;
                end
            end
        end
    end

endmodule

// File: tb/tb_stdp_lif_array.sv
// Directed self-checking bench for stdp_lif_array using hand-computed expected values.
module tb_stdp_lif_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       learn_en = 1'b0;
    logic [7:0] in_spike = '0;
    logic [2:0] w_sel = '0;
    logic       w_wr = 1'b0;
    logic [7:0] w_wdata = '0;
    logic [7:0] w_rdata;
    logic       spike;
    logic [7:0] state;

    int total = 0;
    int bad = 0;

    stdp_lif_array dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .learn_en(learn_en),
        .in_spike(in_spike),
        .w_sel   (w_sel),
        .w_wr    (w_wr),
        .w_wdata (w_wdata),
        .w_rdata (w_rdata),
        .spike   (spike),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge with the given inputs; outputs are settled 1ns after the edge.
    task automatic applyStimulus(input logic [7:0] sp, input logic e, input logic le,
                                 input logic wr, input logic [2:0] sel,
                                 input logic [7:0] wdata);
        in_spike = sp;
        en       = e;
        learn_en = le;
        w_wr     = wr;
        w_sel    = sel;
        w_wdata  = wdata;
        @(posedge clk);
        #1;
        w_wr     = 1'b0;
        in_spike = '0;
        en       = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic hostWrite(input logic [2:0] sel, input logic [7:0] data);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, sel, data);
    endtask

    task automatic step(input logic [7:0] sp, input logic le);
        applyStimulus(sp, 1'b1, le, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic checkWeight(input string tag, input logic [2:0] sel, input int expected);
        w_sel = sel;
        #1;
        checkOutput(tag, 32'(w_rdata), expected);
    endtask

    initial begin
        // Reset state.
        doReset();
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_spike", 32'(spike), 0);
        for (int i = 0; i < 8; i++) checkWeight($sformatf("reset_w%0d", i), 3'(i), 16);

        // Fire and refractory window.
        hostWrite(3'd0, 8'd200);
        step(8'h01, 1'b0);
        checkOutput("fire_spike", 32'(spike), 1);
        checkOutput("fire_state", 32'(state), 0);
        for (int k = 0; k < 3; k++) begin
            step(8'h01, 1'b0);
            checkOutput($sformatf("refr%0d_spike", k), 32'(spike), 0);
            checkOutput($sformatf("refr%0d_state", k), 32'(state), 0);
        end
        step(8'h01, 1'b0);
        checkOutput("refr_end_spike", 32'(spike), 1);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        checkOutput("en0_spike_drop", 32'(spike), 0);
        checkOutput("en0_state_hold", 32'(state), 0);

        // Leak sequence.
        doReset();
        hostWrite(3'd0, 8'd64);
        step(8'h01, 1'b0);
        checkOutput("leak_0", 32'(state), 64);
        step(8'h00, 1'b0);
        checkOutput("leak_1", 32'(state), 56);
        step(8'h00, 1'b0);
        checkOutput("leak_2", 32'(state), 49);
        step(8'h00, 1'b0);
        checkOutput("leak_3", 32'(state), 43);

        // LTP: ch1 precedes the firing ch0 spike by one step.
        doReset();
        hostWrite(3'd0, 8'd200);
        step(8'h02, 1'b1);
        checkOutput("ltp_pre_state", 32'(state), 16);
        step(8'h01, 1'b1);
        checkOutput("ltp_spike", 32'(spike), 1);
        checkWeight("ltp_w0", 3'd0, 208);
        checkWeight("ltp_w1", 3'd1, 24);
        for (int i = 2; i < 8; i++) checkWeight($sformatf("ltp_w%0d", i), 3'(i), 16);

        // LTD inside the post window, including clamping at zero.
        step(8'h00, 1'b1);
        step(8'h04, 1'b1);
        checkWeight("ltd_w2", 3'd2, 12);
        hostWrite(3'd3, 8'd2);
        step(8'h08, 1'b1);
        checkWeight("ltd_w3_floor", 3'd3, 0);
        checkWeight("ltd_w0_kept", 3'd0, 208);

        // LTP clamping at the top.
        doReset();
        hostWrite(3'd0, 8'd252);
        step(8'h01, 1'b1);
        checkOutput("ltp_sat_spike", 32'(spike), 1);
        checkWeight("ltp_sat_w0", 3'd0, 255);

        // Integration overflow saturates instead of wrapping.
        doReset();
        for (int i = 0; i < 8; i++) hostWrite(3'(i), 8'd255);
        step(8'hFF, 1'b0);
        checkOutput("ovf_all_spike", 32'(spike), 1);
        doReset();
        hostWrite(3'd0, 8'd255);
        hostWrite(3'd1, 8'd1);
        step(8'h03, 1'b0);
        checkOutput("ovf_256_spike", 32'(spike), 1);

        // Host write beats a same-edge LTP update; other channels still learn.
        doReset();
        hostWrite(3'd0, 8'd200);
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 3'd0, 8'd5);
        checkOutput("prio_spike", 32'(spike), 1);
        checkWeight("prio_w0", 3'd0, 5);
        checkWeight("prio_w1", 3'd1, 24);

        // Reset in the middle of refractory clears neuron, traces and weights.
        step(8'h00, 1'b1);
        rst = 1'b1;
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        rst = 1'b0;
        checkOutput("rst_refr_state", 32'(state), 0);
        checkOutput("rst_refr_spike", 32'(spike), 0);
        checkWeight("rst_refr_w0", 3'd0, 16);
        checkWeight("rst_refr_w1", 3'd1, 16);
        step(8'h01, 1'b1);
        checkOutput("post_rst_state", 32'(state), 16);
        checkWeight("post_rst_w0", 3'd0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
